// File: rtl/beta_exe_lsu.sv
//------------------------------------------------------------------------------
// beta_exe_lsu : execute-stage load/store unit, single-outstanding data bus port
// Optional watchdog on REQ/RESP waits: define BETA_LSU_TIMEOUT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module beta_exe_lsu #(
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 lsu_en_i,
  input  logic                 lsu_op_i,
  input  logic [1:0]           lsu_op_size_i,
  input  logic                 lsu_unsigned_i,
  input  logic [DataWidth-1:0] lsu_addr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 lsu_busy_o,
  output logic [DataWidth-1:0] lsu_rdata_o,
  output logic                 lsu_err_o,
  output logic                 data_req_o,
  input  logic                 data_gnt_i,
  output logic [DataWidth-1:0] data_addr_o,
  output logic                 data_we_o,
  output logic [3:0]           data_be_o,
  output logic [DataWidth-1:0] data_wdata_o,
  input  logic                 data_rvalid_i,
  input  logic [DataWidth-1:0] data_rdata_i,
  input  logic                 data_err_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 op_q, op_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic [DataWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic                 misaligned;
  logic                 timeout;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [DataWidth-1:0] load_ext;
  logic [3:0]           be;

  assign misaligned = (lsu_op_size_i == 2'b11) ||
                      ((lsu_op_size_i == 2'b01) && lsu_addr_i[0]) ||
                      ((lsu_op_size_i == 2'b10) && (lsu_addr_i[1:0] != 2'b00));

  always_comb begin
    ld_byte = data_rdata_i[7:0];
    case (addr_q[1:0])
      2'd1:    ld_byte = data_rdata_i[15:8];
      2'd2:    ld_byte = data_rdata_i[23:16];
      2'd3:    ld_byte = data_rdata_i[31:24];
      default: ld_byte = data_rdata_i[7:0];
    endcase
    ld_half = addr_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: load_ext = data_rdata_i;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00:   be = 4'b0001 << addr_q[1:0];
      2'b01:   be = 4'b0011 << addr_q[1:0];
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

`ifdef BETA_LSU_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles) + 1;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Restarts on every state change so REQ and RESP each get a full budget.
  always_comb begin
    cnt_d = '0;
    if (((state_q == REQ) || (state_q == RESP)) && (state_d == state_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign timeout = (cnt_q == CntW'(TimeoutCycles - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (lsu_en_i) begin
          op_d    = lsu_op_i;
          size_d  = lsu_op_size_i;
          uns_d   = lsu_unsigned_i;
          addr_d  = lsu_addr_i;
          wdata_d = lsu_wdata_i;
          err_d   = 1'b0;
          state_d = misaligned ? ERR : REQ;
        end
      end
      REQ: begin
        if (data_gnt_i) begin
          state_d = RESP;
        end else if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      RESP: begin
        if (data_rvalid_i) begin
          state_d = IDLE;
          err_d   = data_err_i;
          if (!op_q) rdata_d = load_ext;
        end else if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      ERR: begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Bus outputs derive only from registered state, so they hold steady until grant.
  assign data_req_o   = (state_q == REQ);
  assign data_addr_o  = {addr_q[DataWidth-1:2], 2'b00};
  assign data_we_o    = data_req_o & op_q;
  assign data_be_o    = data_req_o ? be : 4'b0000;
  assign data_wdata_o = (size_q == 2'b00) ? {4{wdata_q[7:0]}} :
                        (size_q == 2'b01) ? {2{wdata_q[15:0]}} : wdata_q;

  assign lsu_busy_o  = (state_q != IDLE);
  assign lsu_rdata_o = rdata_q;
  assign lsu_err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_beta_exe_lsu.sv
//------------------------------------------------------------------------------
// tb_beta_exe_lsu : directed vector bench for beta_exe_lsu
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_beta_exe_lsu;

  localparam int TMO = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lsu_en_i, lsu_op_i, lsu_unsigned_i;
  logic [1:0]  lsu_op_size_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_busy_o, lsu_err_o;
  logic [31:0] lsu_rdata_o;
  logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i, data_err_i;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]  data_be_o;

  int total = 0;
  int bad   = 0;

  beta_exe_lsu #(.DataWidth(32), .TimeoutCycles(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lsu_en_i(lsu_en_i), .lsu_op_i(lsu_op_i), .lsu_op_size_i(lsu_op_size_i),
    .lsu_unsigned_i(lsu_unsigned_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_busy_o(lsu_busy_o), .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        op;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err_in;
    int          gnt_dly;
    int          rv_dly;
    int          exp_req_n;
    int          exp_busy_n;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_bus();
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
    data_rdata_i  = 32'h0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int busy_n, req_n, resp_n;
    logic [31:0] a0, wd0;
    logic [3:0]  be0;
    logic        we0, unstable, done;
    lsu_en_i = 1'b1; lsu_op_i = v.op; lsu_op_size_i = v.size;
    lsu_unsigned_i = v.uns; lsu_addr_i = v.addr; lsu_wdata_i = v.wdata;
    tick();
    lsu_en_i = 1'b0;
    chk($sformatf("v%0d_busy_rise", idx), {31'b0, lsu_busy_o}, 32'd1);
    busy_n = 0; req_n = 0; resp_n = 0; unstable = 1'b0; done = 1'b0;
    a0 = '0; wd0 = '0; be0 = '0; we0 = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      clear_bus();
      if (!lsu_busy_o) begin
        done = 1'b1;
      end else begin
        busy_n++;
        if (data_req_o) begin
          if (req_n == 0) begin
            a0 = data_addr_o; be0 = data_be_o; wd0 = data_wdata_o; we0 = data_we_o;
            chk($sformatf("v%0d_addr", idx), data_addr_o, v.exp_addr);
            chk($sformatf("v%0d_be", idx), {28'b0, data_be_o}, {28'b0, v.exp_be});
            chk($sformatf("v%0d_we", idx), {31'b0, data_we_o}, {31'b0, v.op});
            if (v.op) chk($sformatf("v%0d_wdata", idx), data_wdata_o, v.exp_wdata);
          end else if (a0 !== data_addr_o || be0 !== data_be_o ||
                       wd0 !== data_wdata_o || we0 !== data_we_o) begin
            unstable = 1'b1;
          end
          req_n++;
          if (req_n == v.gnt_dly + 1) data_gnt_i = 1'b1;
        end else if (req_n > 0) begin
          resp_n++;
          if (resp_n == v.rv_dly + 1) begin
            data_rvalid_i = 1'b1;
            data_rdata_i  = v.rdata;
            data_err_i    = v.err_in;
          end
        end
        tick();
      end
    end
    clear_bus();
    chk($sformatf("v%0d_done", idx), {31'b0, done}, 32'd1);
    chk($sformatf("v%0d_req_cycles", idx), busy_n == 0 ? 32'hFFFF : req_n, v.exp_req_n);
    chk($sformatf("v%0d_busy_cycles", idx), busy_n, v.exp_busy_n);
    chk($sformatf("v%0d_stable", idx), {31'b0, unstable}, 32'd0);
    chk($sformatf("v%0d_rdata", idx), lsu_rdata_o, v.exp_rdata);
    chk($sformatf("v%0d_err", idx), {31'b0, lsu_err_o}, {31'b0, v.exp_err});
  endtask

  initial begin
    int req_hi;
    // op size uns addr wdata rdata err_in gnt rv | req busy addr be wdata rdata err
    vecs[0]  = '{0, 2'b10, 0, 32'h100, 32'h11223344, 32'hDEADBEEF, 0, 0, 2, 1, 4, 32'h100, 4'hF, 32'h11223344, 32'hDEADBEEF, 0};
    vecs[1]  = '{0, 2'b00, 0, 32'h203, 32'h0, 32'h80FF1234, 0, 0, 0, 1, 2, 32'h200, 4'h8, 32'h0, 32'hFFFFFF80, 0};
    vecs[2]  = '{0, 2'b00, 1, 32'h203, 32'h0, 32'h80FF1234, 0, 1, 0, 2, 3, 32'h200, 4'h8, 32'h0, 32'h00000080, 0};
    vecs[3]  = '{1, 2'b01, 0, 32'h302, 32'h0000ABCD, 32'hFFFFFFFF, 0, 3, 0, 4, 5, 32'h300, 4'hC, 32'hABCDABCD, 32'h00000080, 0};
    vecs[4]  = '{0, 2'b10, 0, 32'h101, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'h0, 4'h0, 32'h0, 32'h00000080, 1};
    vecs[5]  = '{0, 2'b01, 0, 32'h102, 32'h0, 32'h80017FFF, 0, 1, 1, 2, 4, 32'h100, 4'hC, 32'h0, 32'hFFFF8001, 0};
    vecs[6]  = '{0, 2'b01, 1, 32'h100, 32'h0, 32'h8001F00D, 0, 0, 0, 1, 2, 32'h100, 4'h3, 32'h0, 32'h0000F00D, 0};
    vecs[7]  = '{1, 2'b00, 0, 32'h001, 32'h000000A5, 32'h0, 0, 0, 1, 1, 3, 32'h000, 4'h2, 32'hA5A5A5A5, 32'h0000F00D, 0};
    vecs[8]  = '{0, 2'b00, 0, 32'h000, 32'h0, 32'h1234567F, 0, 0, 0, 1, 2, 32'h000, 4'h1, 32'h0, 32'h0000007F, 0};
    vecs[9]  = '{0, 2'b11, 0, 32'h000, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'h0, 4'h0, 32'h0, 32'h0000007F, 1};
    vecs[10] = '{1, 2'b10, 0, 32'h010, 32'h12345678, 32'h0, 1, 0, 0, 1, 2, 32'h010, 4'hF, 32'h12345678, 32'h0000007F, 1};
    vecs[11] = '{0, 2'b01, 0, 32'h103, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'h0, 4'h0, 32'h0, 32'h0000007F, 1};
    vecs[12] = '{0, 2'b00, 0, 32'h501, 32'h0, 32'h0000C300, 0, 0, 0, 1, 2, 32'h500, 4'h2, 32'h0, 32'hFFFFFFC3, 0};

    rst_i = 1'b1; lsu_en_i = 1'b0; lsu_op_i = 1'b0; lsu_op_size_i = 2'b00;
    lsu_unsigned_i = 1'b0; lsu_addr_i = '0; lsu_wdata_i = '0;
    clear_bus();
    tick(); tick();
    chk("rst_busy", {31'b0, lsu_busy_o}, 32'd0);
    chk("rst_req", {31'b0, data_req_o}, 32'd0);
    chk("rst_rdata", lsu_rdata_o, 32'd0);
    chk("rst_err", {31'b0, lsu_err_o}, 32'd0);
    chk("rst_be_we", {27'b0, data_be_o, data_we_o}, 32'd0);
    rst_i = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Second enable during busy is dropped; bus error on rvalid becomes sticky err.
    lsu_en_i = 1'b1; lsu_op_i = 1'b0; lsu_op_size_i = 2'b10; lsu_addr_i = 32'h40;
    tick();
    lsu_addr_i = 32'h80;
    tick();
    lsu_en_i = 1'b0; data_gnt_i = 1'b1;
    chk("dup_req", {31'b0, data_req_o}, 32'd1);
    chk("dup_addr", data_addr_o, 32'h40);
    tick();
    data_gnt_i = 1'b0;
    chk("dup_req_drop", {31'b0, data_req_o}, 32'd0);
    data_rvalid_i = 1'b1; data_err_i = 1'b1; data_rdata_i = 32'h55;
    tick();
    clear_bus();
    chk("dup_busy_fall", {31'b0, lsu_busy_o}, 32'd0);
    chk("dup_err", {31'b0, lsu_err_o}, 32'd1);
    chk("dup_rdata", lsu_rdata_o, 32'h55);
    req_hi = 0;
    for (int c = 0; c < 4; c++) begin
      if (data_req_o || lsu_busy_o) req_hi++;
      tick();
    end
    chk("dup_not_queued", req_hi, 0);

    // rvalid coincident with grant must not complete the access.
    lsu_en_i = 1'b1; lsu_addr_i = 32'h0; lsu_op_size_i = 2'b10;
    tick();
    lsu_en_i = 1'b0;
    data_gnt_i = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'h99;
    tick();
    clear_bus();
    chk("gntrv_still_busy", {31'b0, lsu_busy_o}, 32'd1);
    data_rvalid_i = 1'b1; data_rdata_i = 32'h77;
    tick();
    clear_bus();
    chk("gntrv_busy_fall", {31'b0, lsu_busy_o}, 32'd0);
    chk("gntrv_rdata", lsu_rdata_o, 32'h77);
    chk("gntrv_err", {31'b0, lsu_err_o}, 32'd0);

    // Grant never arrives: watchdog (if built in) or indefinite wait, then async reset.
    lsu_en_i = 1'b1; lsu_addr_i = 32'h20;
    tick();
    lsu_en_i = 1'b0;
    req_hi = 0;
    for (int c = 0; c < 20; c++) begin
      if (data_req_o) req_hi++;
      tick();
    end
`ifdef BETA_LSU_TIMEOUT_EN
    chk("tmo_req_cycles", req_hi, TMO);
    chk("tmo_busy", {31'b0, lsu_busy_o}, 32'd0);
    chk("tmo_err", {31'b0, lsu_err_o}, 32'd1);
    lsu_en_i = 1'b1;
    tick();
    lsu_en_i = 1'b0;
`else
    chk("notmo_req_cycles", req_hi, 20);
    chk("notmo_busy", {31'b0, lsu_busy_o}, 32'd1);
`endif
    rst_i = 1'b1;
    #1;
    chk("arst_req", {31'b0, data_req_o}, 32'd0);
    chk("arst_busy", {31'b0, lsu_busy_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFEF00D;
    tick();
    clear_bus();
    chk("late_rv_busy", {31'b0, lsu_busy_o}, 32'd0);
    chk("late_rv_rdata", lsu_rdata_o, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/beta_exe_lsu.md
Name: beta_exe_lsu

Overview:
Load & Store Unit for the execute stage, and the responder side of the exe control unit's LSU enable/busy handshake. It accepts one memory operation per enable pulse and runs a single-outstanding request/grant/rvalid transaction on the data-memory port. It returns size-aligned, extended load data and raises busy for the whole operation.

Parameters:
DataWidth, 32, data and address width; only 32 supported.
TimeoutCycles, 64, watchdog limit in cycles; used only with the optional feature.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
lsu_en_i  in  1  start request from exe CU
lsu_op_i  in  1  0 = load, 1 = store
lsu_op_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved
lsu_unsigned_i  in  1  1 = zero-extend loads (LBU/LHU)
lsu_addr_i  in  32  effective byte address
lsu_wdata_i  in  32  store data, LSB-justified
lsu_busy_o  out  1  operation in progress
lsu_rdata_o  out  32  extended load result
lsu_err_o  out  1  sticky error for the last operation
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant
data_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
data_we_o  out  1  write enable
data_be_o  out  4  byte enables
data_wdata_o  out  32  lane-aligned store data
data_rvalid_i  in  1  response valid
data_rdata_i  in  32  raw read word
data_err_i  in  1  bus error, qualified by rvalid

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- FSM states: IDLE, REQ, RESP, ERR.
- IDLE:
  - lsu_en_i=1 is sampled at a rising edge.
  - op, size, unsigned, addr and wdata are latched into internal registers.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]!=0, or size=11) -> ERR.
  - Otherwise -> REQ.
  - In both cases lsu_busy_o=1 from the next cycle, and lsu_err_o is cleared.
- REQ:
  - data_req_o=1 with addr/we/be/wdata driven from the latched registers.
  - These signals must stay stable until data_gnt_i=1; on grant -> RESP, and req drops the next cycle.
- RESP:
  - Waits for data_rvalid_i. rvalid is never expected in the grant cycle; if it arrives there it is ignored.
  - On rvalid -> IDLE and busy=0 next cycle.
  - For loads, lsu_rdata_o is loaded in the same edge:
    - Byte: lane addr[1:0] selected.
    - Half: lane addr[1].
    - Result sign- or zero-extended per lsu_unsigned_i.
  - Stores leave lsu_rdata_o unchanged.
  - lsu_err_o <= data_err_i.
- ERR: no bus transaction; lsu_err_o=1; busy stays high exactly one cycle -> IDLE.
- Minimum busy length is 1 cycle. Busy rises exactly one cycle after en is accepted, so the CU can see busy=1 before it drops en.
- lsu_rdata_o and lsu_err_o hold until the next accepted operation.
- lsu_en_i while busy=1 is ignored and never queued. en held high across the busy-falling edge starts a new operation (the CU must drop en, which it does).
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- Store data lanes: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
- Reset mid-operation: FSM returns to IDLE and data_req_o drops immediately (asynchronous). Any outstanding rvalid after reset is ignored.

Optional Feature:
- Macro: BETA_LSU_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to REQ and again on entry to RESP, and increments each cycle in those states.
  - When the count reaches TimeoutCycles-1 with no gnt (REQ) or no rvalid (RESP) -> IDLE with lsu_err_o=1, data_req_o=0, and busy falls the next cycle.
  - A late rvalid arriving in IDLE is ignored.
- Disabled: no counter; REQ and RESP wait indefinitely.

Test Plan:
- LW at 0x100, gnt in the first REQ cycle, rvalid 2 cycles later with 0xDEADBEEF -> req for 1 cycle, addr 0x100, be 1111; busy high 4 cycles; rdata 0xDEADBEEF; err 0.
- LB at 0x203, rdata 0x80FF_1234 -> be 1000; rdata 0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH at 0x302, wdata 0x0000ABCD, gnt delayed 3 cycles -> req, addr 0x300, be 1100, wdata 0xABCDABCD stable for 4 cycles; we=1.
- LW at 0x101 -> no req; busy high 1 cycle; err=1; rdata unchanged.
- en pulsed again while busy, then rvalid with data_err_i=1 -> second en ignored; err=1; exactly one bus transaction.
- With BETA_LSU_TIMEOUT_EN and TimeoutCycles=8, gnt never asserted -> req drops after 8 cycles; err=1; busy falls. Without the macro, busy stays high.
